// File: rtl/yasac_uart_tx_if.sv
// Processor-port bundle for the YASAC serial transmitter.
// The processor drives data/ctrl, and the transmitter returns status and the line.
interface yasac_uart_tx_if;
    logic [7:0] data_in;
    logic [7:0] ctrl_in;
    logic [7:0] status_out;
    logic       tx;

    modport master (output data_in, output ctrl_in, input status_out, input tx);
    modport slave  (input data_in, input ctrl_in, output status_out, output tx);
endinterface

// File: rtl/yasac_uart_tx.sv
// 8N1 serial transmitter with a one-byte holding buffer, fed from YASAC output ports.
// Status (busy/full/overrun/tx) is decoded from registers only.
module yasac_uart_tx #(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic           clk,
    input  logic           reset,
    yasac_uart_tx_if.slave u
);
    localparam int unsigned BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    buf_q, buf_d;
    logic          full_q, full_d;
    logic          ovr_q, ovr_d;
    logic          tx_q, tx_d;
    logic          prev0_q, prev1_q;
    logic          send_edge, clr_edge, baud_end, drain, ovr_set;
    logic          unused_ctrl;

    assign unused_ctrl = ^u.ctrl_in[7:2];
    assign send_edge   = u.ctrl_in[0] & ~prev0_q;
    assign clr_edge    = u.ctrl_in[1] & ~prev1_q;
    assign baud_end    = (baud_q == BAUD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            buf_q   <= '0;
            full_q  <= 1'b0;
            ovr_q   <= 1'b0;
            tx_q    <= 1'b1;
            prev0_q <= 1'b1;
            prev1_q <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            buf_q   <= buf_d;
            full_q  <= full_d;
            ovr_q   <= ovr_d;
            tx_q    <= tx_d;
            prev0_q <= u.ctrl_in[0];
            prev1_q <= u.ctrl_in[1];
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        buf_d   = buf_q;
        full_d  = full_q;
        ovr_d   = ovr_q;
        drain   = 1'b0;
        ovr_set = 1'b0;
        tx_d    = 1'b1;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (full_q) begin
                    drain   = 1'b1;
                    shift_d = buf_q;
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Pending byte chains straight into the next start bit.
                    if (full_q) begin
                        drain   = 1'b1;
                        shift_d = buf_q;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A send arriving while the buffer drains refills it without overrun.
        if (drain) full_d = 1'b0;
        if (send_edge) begin
            if (!full_q || drain) begin
                buf_d  = u.data_in;
                full_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end

        if (ovr_set)       ovr_d = 1'b1;
        else if (clr_edge) ovr_d = 1'b0;

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign u.tx         = tx_q;
    assign u.status_out = {4'b0000, tx_q, ovr_q, full_q, (state_q != IDLE)};
endmodule

// File: tb/tb_yasac_uart_tx.sv
// Directed bench for yasac_uart_tx at CLK_DIV=4: framing, buffering, overrun, reset.
module tb_yasac_uart_tx;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    yasac_uart_tx_if bus ();

    yasac_uart_tx #(.CLK_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .u     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected line level at cycle j (0..39) of an 8N1 frame, 4 cycles per bit.
    function automatic logic fbit(input logic [7:0] b, input int unsigned j);
        int unsigned idx;
        idx = j / 4;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
    endfunction

    // Rising send edge with byte b; returns at the first start-bit cycle.
    task automatic send_start(input logic [7:0] b);
        bus.ctrl_in = 8'h00;
        tick();
        bus.data_in = b;
        bus.ctrl_in = 8'h01;
        tick();
        chk("send_full", bus.status_out, 8'h0A);
        tick();
        chk("send_start", bus.status_out, 8'h01);
    endtask

    initial begin
        reset       = 1'b0;
        bus.data_in = 8'hFF;
        bus.ctrl_in = 8'h01;
        repeat (3) tick();
        chk("rst_tx", 8'(bus.tx), 8'h01);
        chk("rst_status", bus.status_out, 8'h08);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_status", bus.status_out, 8'h08);
        end

        // Single frame
        send_start(8'hA5);
        for (int unsigned i = 0; i < 40; i++) begin
            chk("single_tx", 8'(bus.tx), 8'(fbit(8'hA5, i)));
            chk("single_busy", 8'(bus.status_out[0]), 8'h01);
            tick();
        end
        chk("single_end", bus.status_out, 8'h08);

        // Back-to-back: second byte queued during the first start bit
        send_start(8'h55);
        for (int unsigned i = 0; i < 80; i++) begin
            chk("b2b_tx", 8'(bus.tx), 8'(fbit((i < 40) ? 8'h55 : 8'h0F, i % 40)));
            chk("b2b_full", 8'(bus.status_out[1]), (i >= 2 && i < 40) ? 8'h01 : 8'h00);
            chk("b2b_busy", 8'(bus.status_out[0]), 8'h01);
            if (i == 0) bus.ctrl_in = 8'h00;
            if (i == 1) begin bus.data_in = 8'h0F; bus.ctrl_in = 8'h01; end
            tick();
        end
        chk("b2b_end", bus.status_out, 8'h08);

        // Overrun: third send while one byte shifts and one is buffered
        send_start(8'h33);
        for (int unsigned i = 0; i < 80; i++) begin
            chk("ovr_tx", 8'(bus.tx), 8'(fbit((i < 40) ? 8'h33 : 8'hCC, i % 40)));
            chk("ovr_flag", 8'(bus.status_out[2]), (i >= 4) ? 8'h01 : 8'h00);
            if (i == 0) bus.ctrl_in = 8'h00;
            if (i == 1) begin bus.data_in = 8'hCC; bus.ctrl_in = 8'h01; end
            if (i == 2) bus.ctrl_in = 8'h00;
            if (i == 3) begin bus.data_in = 8'h99; bus.ctrl_in = 8'h01; end
            tick();
        end
        chk("ovr_sticky", bus.status_out, 8'h0C);
        bus.ctrl_in = 8'h02;
        tick();
        chk("ovr_clear", bus.status_out, 8'h08);

        // Send edge on the exact drain cycle at the end of the first stop bit
        send_start(8'hE1);
        for (int unsigned i = 0; i < 120; i++) begin
            logic [7:0] b;
            b = (i < 40) ? 8'hE1 : (i < 80) ? 8'h7E : 8'h3C;
            chk("drain_tx", 8'(bus.tx), 8'(fbit(b, i % 40)));
            chk("drain_full", 8'(bus.status_out[1]), (i >= 2 && i < 80) ? 8'h01 : 8'h00);
            chk("drain_ovr", 8'(bus.status_out[2]), 8'h00);
            if (i == 0) bus.ctrl_in = 8'h00;
            if (i == 1) begin bus.data_in = 8'h7E; bus.ctrl_in = 8'h01; end
            if (i == 38) bus.ctrl_in = 8'h00;
            if (i == 39) begin bus.data_in = 8'h3C; bus.ctrl_in = 8'h01; end
            tick();
        end
        chk("drain_end", bus.status_out, 8'h08);

        // Reset during data bit 3 (cycles 16..19 of the frame)
        send_start(8'h96);
        for (int unsigned i = 0; i < 17; i++) begin
            chk("mid_tx", 8'(bus.tx), 8'(fbit(8'h96, i)));
            tick();
        end
        chk("mid_bit3", 8'(bus.tx), 8'(fbit(8'h96, 17)));
        reset = 1'b0;
        #1;
        chk("mid_rst_tx", 8'(bus.tx), 8'h01);
        chk("mid_rst_status", bus.status_out, 8'h08);
        repeat (2) tick();
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("post_rst_idle", bus.status_out, 8'h08);
        send_start(8'h4B);
        for (int unsigned i = 0; i < 40; i++) begin
            chk("post_rst_tx", 8'(bus.tx), 8'(fbit(8'h4B, i)));
            tick();
        end
        chk("post_rst_end", bus.status_out, 8'h08);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/yasac_uart_tx.md
# yasac_uart_tx

Serial transmitter peripheral attached to the YASAC processor's I/O ports. It consumes a data byte and a control byte from two processor output ports, buffers one byte, and shifts it out as an 8N1 asynchronous serial frame. Its status byte is wired back to a processor input port so software can poll it. It is the first downstream consumer of the processor's output ports.

## Interface
- `CLK_DIV`, default 16: clock cycles per serial bit. Legal values are ≥ 2.
- `clk`, input, 1: clock. All state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `data_in`, input, 8: byte to transmit. Wired to processor `port00`.
- `ctrl_in`, input, 8: control byte. Wired to processor `port01`.
  - bit0 = send request (rising edge).
  - bit1 = overrun clear (rising edge).
  - bits 7:2 are ignored.
- `status_out`, output, 8: status byte. Wired to processor `port08`.
  - bit0 = busy.
  - bit1 = buffer full.
  - bit2 = overrun.
  - bit3 = current `tx` level.
  - bits 7:4 = 0.
- `tx`, output, 1: serial line. Idles high.

## Operation
- **Edge detection:** registers `prev0` and `prev1` hold last cycle's `ctrl_in[0]` and `ctrl_in[1]`.
  - A rising edge is `ctrl_in[i] & ~prev[i]`.
  - Both registers reset to 1, so a bit already high at reset release never triggers. Software must write 0 and then 1.
- **Holding buffer:** an 8-bit register plus a `full` flag.
  - A send edge with `full`=0: `data_in` is captured and `full` is set.
  - A send edge with `full`=1 and the buffer not being drained that cycle: the byte is dropped and `overrun` is set.
- **Shifter FSM**, states IDLE, START, DATA, STOP:
  - IDLE: `tx`=1. If `full`=1, load the shift register from the buffer, clear `full`, and go to START.
  - START: `tx`=0 for CLK_DIV cycles, then go to DATA.
  - DATA: `tx` = shift register bit 0, LSB first. After each CLK_DIV cycles, shift right and increment the 3-bit bit counter. After the 8th bit, go to STOP.
  - STOP: `tx`=1 for CLK_DIV cycles. Then, if `full`=1, load the buffer and go straight to START (back-to-back frames, no idle gap). Otherwise go to IDLE.
- **Drain and send in the same cycle:** the new byte is captured, `full` stays 1, and no overrun is flagged.
- **Overrun clear:** an overrun-clear edge clears `overrun`. If a new overrun occurs in the same cycle, set wins.
- **Counters:** the baud counter is ceil(log2(CLK_DIV)) bits wide. It counts 0..CLK_DIV-1 and wraps to 0 at each bit boundary.
- **`tx` register:** `tx` is registered, with no combinational path from the inputs.
- **Status decode:** `busy` = (state != IDLE). `status_out` is decoded from registers only.

## Timing
- **Reset values:**
  - `tx`=1, `status_out`=8'h08.
  - State IDLE, `full`=0, `overrun`=0, counters 0, `prev0`=`prev1`=1.
- **Reset mid-frame:** the frame is aborted immediately, `tx` returns high asynchronously, and the buffered byte is lost.
- **Send latency:**
  - Send edge sampled at clock edge k: `full`=1 after edge k.
  - START is entered and `tx` falls after edge k+1.
  - `busy`=1 and `full`=0 after edge k+1.
- **Frame length:** exactly 10×CLK_DIV cycles, from `tx` falling to the end of the stop bit.
- **Back-to-back frames:** the next start bit begins on the cycle immediately after the last stop-bit cycle.
- **Buffer depth:** at most two bytes are pending, one shifting and one in the buffer. A third send edge before the buffer drains sets `overrun`.

## Test plan
- **Reset and idle:** reset low, then high, with `ctrl_in`=8'h01 held → `tx` stays 1, `status_out`=8'h08, and no frame is sent.
- **Single frame** (CLK_DIV=4): `data_in`=8'hA5, `ctrl_in` bit0 0→1 → `tx` falls 2 cycles later.
  - Bit sequence 0,1,0,1,0,0,1,0,1,1, each 4 cycles.
  - `busy`=1 throughout; `status_out` returns to 8'h08 after 40 cycles.
- **Back-to-back:** send 8'h55, and during its start bit send 8'h0F → `full`=1 until the first stop bit ends. The second start bit follows with no gap, over 80 contiguous frame cycles.
- **Overrun:** three sends within the first frame → third byte dropped, `status_out` bit2=1 and stays 1 after both frames.
  - Rising edge on `ctrl_in` bit1 → bit2=0.
- **Simultaneous drain and send:** a send edge on the exact cycle the buffer loads into the shifter → no overrun, `full`=1, and the new byte is transmitted in the next frame.
- **Reset mid-frame:** assert reset during DATA bit 3 → `tx`=1 immediately, `status_out`=8'h08. A later send transmits a correct full frame.
